// File: rtl/pokemon_match_ctrl.sv
// Two-player match sequencer: idle/countdown/play/game-over flow, shoot-to-fire gating, HP and winner.
// Optional per-player magazine with timed reload when the macro POKEMON_AMMO_EN is defined.
module pokemon_match_ctrl #(
    parameter int CLK_HZ        = 1000,
    parameter int COUNTDOWN_S   = 3,
    parameter int COOLDOWN_CYC  = 250,
    parameter int START_HP      = 5,
    parameter int OVER_HOLD_CYC = 3000
`ifdef POKEMON_AMMO_EN
    ,
    parameter int AMMO_MAX      = 8,
    parameter int RELOAD_CYC    = 2000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_shoot,
    input  logic       p2_shoot,
    input  logic       p1_proj_done,
    input  logic       p2_proj_done,
    input  logic       p1_hit,
    input  logic       p2_hit,
    output logic [1:0] state,
    output logic [1:0] countdown,
    output logic       play_en,
    output logic       p1_fire,
    output logic       p2_fire,
    output logic [3:0] p1_hp,
    output logic [3:0] p2_hp,
    output logic [1:0] winner
`ifdef POKEMON_AMMO_EN
    ,
    output logic [3:0] p1_ammo,
    output logic [3:0] p2_ammo
`endif
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    // One timer serves both the countdown seconds and the game-over hold.
    localparam int TMR_MAX = (CLK_HZ > OVER_HOLD_CYC) ? CLK_HZ : OVER_HOLD_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int CD_W    = $clog2(COOLDOWN_CYC + 1);

    function automatic logic [3:0] sat_dec(input logic [3:0] v);
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
    endfunction

    state_t           st;
    logic [TMR_W-1:0] timer;
    logic [1:0]       shoot;
    logic [1:0]       shoot_prev;
    logic [1:0]       shoot_rise;
    logic [1:0]       done;
    logic [1:0]       in_flight;
    logic [1:0]       grant;
    logic [CD_W-1:0]  cooldown [2];
    logic [3:0]       p1_hp_nx;
    logic [3:0]       p2_hp_nx;
    logic             start_match;

`ifdef POKEMON_AMMO_EN
    localparam int RL_W = $clog2(RELOAD_CYC + 1);
    logic [3:0]      ammo   [2];
    logic [RL_W-1:0] reload [2];

    assign p1_ammo = ammo[0];
    assign p2_ammo = ammo[1];
`endif

    assign state = st;

    always_comb begin
        shoot       = {p2_shoot, p1_shoot};
        done        = {p2_proj_done, p1_proj_done};
        shoot_rise  = shoot & ~shoot_prev;
        start_match = start && (st == S_IDLE || st == S_OVER);
        p1_hp_nx    = p1_hit ? sat_dec(p1_hp) : p1_hp;
        p2_hp_nx    = p2_hit ? sat_dec(p2_hp) : p2_hp;
        grant       = 2'b00;
        // A done pulse in the same cycle as a new edge consumes that edge.
        for (int i = 0; i < 2; i++) begin
            grant[i] = (st == S_PLAY) && shoot_rise[i] && !done[i] && !in_flight[i]
                       && (cooldown[i] == '0)
`ifdef POKEMON_AMMO_EN
                       && (ammo[i] != 4'd0)
`endif
                       ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= S_IDLE;
            countdown  <= 2'd0;
            play_en    <= 1'b0;
            p1_fire    <= 1'b0;
            p2_fire    <= 1'b0;
            p1_hp      <= 4'(START_HP);
            p2_hp      <= 4'(START_HP);
            winner     <= 2'd0;
            timer      <= '0;
            shoot_prev <= 2'b00;
            in_flight  <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cooldown[i] <= '0;
`ifdef POKEMON_AMMO_EN
                ammo[i]     <= 4'(AMMO_MAX);
                reload[i]   <= '0;
`endif
            end
        end else begin
            shoot_prev <= shoot;
            p1_fire    <= grant[0];
            p2_fire    <= grant[1];
            for (int i = 0; i < 2; i++) begin
                if (grant[i])
                    cooldown[i] <= CD_W'(COOLDOWN_CYC);
                else if (cooldown[i] != '0)
                    cooldown[i] <= cooldown[i] - CD_W'(1);
`ifdef POKEMON_AMMO_EN
                // Reload timer only runs while the magazine is empty.
                if (start_match) begin
                    ammo[i]   <= 4'(AMMO_MAX);
                    reload[i] <= '0;
                end else if (grant[i]) begin
                    ammo[i] <= ammo[i] - 4'd1;
                end else if (ammo[i] == 4'd0) begin
                    if (reload[i] == RL_W'(RELOAD_CYC - 1)) begin
                        ammo[i]   <= 4'(AMMO_MAX);
                        reload[i] <= '0;
                    end else begin
                        reload[i] <= reload[i] + RL_W'(1);
                    end
                end
`endif
            end

            if (start_match) begin
                st        <= S_COUNT;
                countdown <= 2'(COUNTDOWN_S);
                timer     <= '0;
                p1_hp     <= 4'(START_HP);
                p2_hp     <= 4'(START_HP);
                winner    <= 2'd0;
                in_flight <= 2'b00;
            end else begin
                case (st)
                    S_COUNT: begin
                        if (timer == TMR_W'(CLK_HZ - 1)) begin
                            timer <= '0;
                            if (countdown == 2'd1) begin
                                st        <= S_PLAY;
                                countdown <= 2'd0;
                                play_en   <= 1'b1;
                            end else begin
                                countdown <= countdown - 2'd1;
                            end
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                    S_PLAY: begin
                        in_flight <= (in_flight & ~done) | grant;
                        p1_hp     <= p1_hp_nx;
                        p2_hp     <= p2_hp_nx;
                        // winner bit 1 flags P1 knocked out, bit 0 flags P2.
                        if (p1_hp_nx == 4'd0 || p2_hp_nx == 4'd0) begin
                            st      <= S_OVER;
                            play_en <= 1'b0;
                            timer   <= '0;
                            winner  <= {p1_hp_nx == 4'd0, p2_hp_nx == 4'd0};
                        end
                    end
                    S_OVER: begin
                        in_flight <= 2'b00;
                        if (timer == TMR_W'(OVER_HOLD_CYC - 1)) begin
                            st    <= S_IDLE;
                            timer <= '0;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pokemon_match_ctrl.sv
// Self-checking bench for pokemon_match_ctrl: directed scenarios plus randomized play
// checked against a timestamp-based behavioural model of the match rules.
module tb_pokemon_match_ctrl;
    localparam int CLK_HZ = 1000, COUNTDOWN_S = 3, COOLDOWN_CYC = 250;
    localparam int START_HP = 5, OVER_HOLD_CYC = 3000, AMMO_MAX = 8, RELOAD_CYC = 2000;

    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0;
    logic p1_shoot = 1'b0, p2_shoot = 1'b0, p1_proj_done = 1'b0, p2_proj_done = 1'b0;
    logic p1_hit = 1'b0, p2_hit = 1'b0;
    logic [1:0] state, countdown, winner;
    logic play_en, p1_fire, p2_fire;
    logic [3:0] p1_hp, p2_hp;
`ifdef POKEMON_AMMO_EN
    logic [3:0] p1_ammo, p2_ammo;
`endif

    int n_tests = 0, n_fail = 0;

    pokemon_match_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .p1_shoot(p1_shoot), .p2_shoot(p2_shoot),
        .p1_proj_done(p1_proj_done), .p2_proj_done(p2_proj_done),
        .p1_hit(p1_hit), .p2_hit(p2_hit),
        .state(state), .countdown(countdown), .play_en(play_en),
        .p1_fire(p1_fire), .p2_fire(p2_fire),
        .p1_hp(p1_hp), .p2_hp(p2_hp), .winner(winner)
`ifdef POKEMON_AMMO_EN
        , .p1_ammo(p1_ammo), .p2_ammo(p2_ammo)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: phases with start/over timestamps, cooldown as time since last grant.
    int cyc = 0;
    int m_phase = 0, m_t0 = 0, m_cd = 0, m_hp1 = START_HP, m_hp2 = START_HP, m_win = 0;
    int m_last1 = -1000000, m_last2 = -1000000;
    int m_ammo1 = AMMO_MAX, m_ammo2 = AMMO_MAX, m_empty1 = 0, m_empty2 = 0;
    bit m_play = 0, m_fire1 = 0, m_fire2 = 0, m_prev1 = 0, m_prev2 = 0, m_busy1 = 0, m_busy2 = 0;

    always @(posedge clk) begin
        int e, h1, h2;
        bit f1, f2, ammo_ok1, ammo_ok2, go;
        cyc++;
        if (reset) begin
            m_phase = 0; m_cd = 0; m_play = 0; m_fire1 = 0; m_fire2 = 0;
            m_hp1 = START_HP; m_hp2 = START_HP; m_win = 0;
            m_prev1 = 0; m_prev2 = 0; m_busy1 = 0; m_busy2 = 0;
            m_last1 = -1000000; m_last2 = -1000000;
            m_ammo1 = AMMO_MAX; m_ammo2 = AMMO_MAX;
        end else begin
            ammo_ok1 = 1; ammo_ok2 = 1;
`ifdef POKEMON_AMMO_EN
            ammo_ok1 = (m_ammo1 > 0); ammo_ok2 = (m_ammo2 > 0);
`endif
            f1 = (m_phase == 2) && p1_shoot && !m_prev1 && !p1_proj_done && !m_busy1
                 && (cyc - m_last1 > COOLDOWN_CYC) && ammo_ok1;
            f2 = (m_phase == 2) && p2_shoot && !m_prev2 && !p2_proj_done && !m_busy2
                 && (cyc - m_last2 > COOLDOWN_CYC) && ammo_ok2;
            if (f1) m_last1 = cyc;
            if (f2) m_last2 = cyc;
            go = start && (m_phase == 0 || m_phase == 3);
            if (go) begin
                m_phase = 1; m_t0 = cyc; m_cd = COUNTDOWN_S; m_hp1 = START_HP; m_hp2 = START_HP;
                m_win = 0; m_busy1 = 0; m_busy2 = 0;
            end else if (m_phase == 1) begin
                e = cyc - m_t0;
                if (e >= COUNTDOWN_S * CLK_HZ) begin m_phase = 2; m_cd = 0; m_play = 1; end
                else m_cd = COUNTDOWN_S - e / CLK_HZ;
            end else if (m_phase == 2) begin
                if (p1_proj_done) m_busy1 = 0;
                if (p2_proj_done) m_busy2 = 0;
                if (f1) m_busy1 = 1;
                if (f2) m_busy2 = 1;
                h1 = m_hp1 - (p1_hit ? 1 : 0); if (h1 < 0) h1 = 0;
                h2 = m_hp2 - (p2_hit ? 1 : 0); if (h2 < 0) h2 = 0;
                m_hp1 = h1; m_hp2 = h2;
                if (h1 == 0 || h2 == 0) begin
                    m_phase = 3; m_t0 = cyc; m_play = 0;
                    m_win = (h1 == 0 && h2 == 0) ? 3 : (h2 == 0) ? 1 : 2;
                end
            end else if (m_phase == 3) begin
                m_busy1 = 0; m_busy2 = 0;
                if (cyc - m_t0 >= OVER_HOLD_CYC) m_phase = 0;
            end
            if (go) begin
                m_ammo1 = AMMO_MAX; m_ammo2 = AMMO_MAX;
            end else begin
                if (f1 && ammo_ok1) begin m_ammo1--; if (m_ammo1 == 0) m_empty1 = cyc; end
                else if (m_ammo1 == 0 && cyc - m_empty1 >= RELOAD_CYC) m_ammo1 = AMMO_MAX;
                if (f2 && ammo_ok2) begin m_ammo2--; if (m_ammo2 == 0) m_empty2 = cyc; end
                else if (m_ammo2 == 0 && cyc - m_empty2 >= RELOAD_CYC) m_ammo2 = AMMO_MAX;
            end
            m_fire1 = f1; m_fire2 = f2;
            m_prev1 = p1_shoot; m_prev2 = p2_shoot;
        end
    end

    function automatic logic [16:0] dut_vec();
        return {state, countdown, play_en, p1_fire, p2_fire, p1_hp, p2_hp, winner};
    endfunction

    function automatic logic [16:0] model_vec();
        return {2'(m_phase), 2'(m_cd), m_play, m_fire1, m_fire2, 4'(m_hp1), 4'(m_hp2), 2'(m_win)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_tests++;
        if (dut_vec() !== {2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd5, 4'd5, 2'd0}) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", dut_vec(), {2'd0, 2'd0, 3'b000, 4'd5, 4'd5, 2'd0});
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if (dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL idle_after_reset: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_countdown();
        start = 1'b1; tick(); start = 1'b0;
        n_tests++;
        if (state !== 2'd1 || countdown !== 2'd3) begin
            n_fail++; $display("FAIL countdown_begin: state=%0d cd=%0d expected 1/3", state, countdown);
        end
        p1_hit = 1'b1; tick(); p1_hit = 1'b0;
        for (int k = 2; k <= 3000; k++) begin
            tick();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL countdown_cycle %0d: got %h expected %h", k, dut_vec(), model_vec());
            end
            if (k == 999 || k == 1000 || k == 2000 || k == 2999) begin
                n_tests++;
                if (countdown !== ((k == 999) ? 2'd3 : (k == 2999 || k == 2000) ? 2'd1 : 2'd2)) begin
                    n_fail++; $display("FAIL countdown_value at %0d: got %0d", k, countdown);
                end
            end
        end
        n_tests++;
        if (state !== 2'd2 || play_en !== 1'b1 || countdown !== 2'd0 || p1_hp !== 4'd5) begin
            n_fail++; $display("FAIL play_entry: state=%0d play_en=%b cd=%0d hp=%0d expected 2/1/0/5", state, play_en, countdown, p1_hp);
        end
    endtask

    task automatic test_fire();
        p1_shoot = 1'b1; tick();
        n_tests++;
        if (p1_fire !== 1'b1 || p2_fire !== 1'b0) begin
            n_fail++; $display("FAIL fire_grant: p1_fire=%b p2_fire=%b expected 1/0", p1_fire, p2_fire);
        end
        p1_shoot = 1'b0; tick();
        n_tests++;
        if (p1_fire !== 1'b0) begin n_fail++; $display("FAIL fire_one_cycle: p1_fire=%b expected 0", p1_fire); end
        repeat (98) tick();
        p1_shoot = 1'b1; tick();
        n_tests++;
        if (p1_fire !== 1'b0) begin n_fail++; $display("FAIL fire_in_flight: p1_fire=%b expected 0", p1_fire); end
        p1_shoot = 1'b0; repeat (19) tick();
        p1_proj_done = 1'b1; tick(); p1_proj_done = 1'b0;
        repeat (79) tick();
        p1_shoot = 1'b1; tick();
        n_tests++;
        if (p1_fire !== 1'b0) begin n_fail++; $display("FAIL fire_cooldown: p1_fire=%b expected 0", p1_fire); end
        p1_shoot = 1'b0; repeat (99) tick();
        p1_shoot = 1'b1; tick();
        n_tests++;
        if (p1_fire !== 1'b1 || dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL fire_after_cooldown: p1_fire=%b expected 1 (vec %h vs %h)", p1_fire, dut_vec(), model_vec());
        end
        p1_shoot = 1'b0; tick();
    endtask

    task automatic test_back_to_back();
        repeat (260) tick();
        p1_proj_done = 1'b1; p1_shoot = 1'b1; tick();
        n_tests++;
        if (p1_fire !== 1'b0) begin n_fail++; $display("FAIL done_beats_edge: p1_fire=%b expected 0", p1_fire); end
        p1_proj_done = 1'b0; p1_shoot = 1'b0; tick();
        p1_shoot = 1'b1; p2_shoot = 1'b1; tick();
        n_tests++;
        if (p1_fire !== 1'b1 || p2_fire !== 1'b1) begin
            n_fail++; $display("FAIL both_fire: p1_fire=%b p2_fire=%b expected 1/1", p1_fire, p2_fire);
        end
        p1_shoot = 1'b0; p2_shoot = 1'b0; tick();
    endtask

    task automatic test_draw();
        repeat (4) begin
            p1_hit = 1'b1; p2_hit = 1'b1; tick(); p1_hit = 1'b0; p2_hit = 1'b0; tick();
        end
        n_tests++;
        if (p1_hp !== 4'd1 || p2_hp !== 4'd1 || state !== 2'd2) begin
            n_fail++; $display("FAIL hp_countdown: hp=%0d/%0d state=%0d expected 1/1/2", p1_hp, p2_hp, state);
        end
        p1_hit = 1'b1; p2_hit = 1'b1; tick(); p1_hit = 1'b0; p2_hit = 1'b0;
        n_tests++;
        if (p1_hp !== 4'd0 || p2_hp !== 4'd0 || state !== 2'd3 || winner !== 2'd3 || play_en !== 1'b0) begin
            n_fail++; $display("FAIL draw: hp=%0d/%0d state=%0d winner=%0d play_en=%b expected 0/0/3/3/0", p1_hp, p2_hp, state, winner, play_en);
        end
        for (int k = 1; k <= 2999; k++) begin
            p1_shoot = ((k % 40) < 20); p2_shoot = ((k % 30) < 15);
            tick();
            n_tests++;
            if (state !== 2'd3 || p1_fire !== 1'b0 || p2_fire !== 1'b0 || dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL over_hold %0d: got %h expected %h", k, dut_vec(), model_vec());
            end
        end
        p1_shoot = 1'b0; p2_shoot = 1'b0; tick();
        n_tests++;
        if (state !== 2'd0 || winner !== 2'd3 || p1_hp !== 4'd0) begin
            n_fail++; $display("FAIL over_to_idle: state=%0d winner=%0d hp=%0d expected 0/3/0", state, winner, p1_hp);
        end
    endtask

    task automatic test_p2_ko();
        start = 1'b1; tick(); start = 1'b0;
        n_tests++;
        if (state !== 2'd1 || p1_hp !== 4'd5 || p2_hp !== 4'd5 || winner !== 2'd0) begin
            n_fail++; $display("FAIL restart: state=%0d hp=%0d/%0d winner=%0d expected 1/5/5/0", state, p1_hp, p2_hp, winner);
        end
        repeat (3000) tick();
        n_tests++;
        if (state !== 2'd2) begin n_fail++; $display("FAIL play_reached: state=%0d expected 2", state); end
        repeat (5) begin p2_hit = 1'b1; tick(); p2_hit = 1'b0; tick(); end
        n_tests++;
        if (p2_hp !== 4'd0 || p1_hp !== 4'd5 || winner !== 2'd1 || state !== 2'd3) begin
            n_fail++; $display("FAIL p1_wins: hp=%0d/%0d winner=%0d state=%0d expected 5/0/1/3", p1_hp, p2_hp, winner, state);
        end
        repeat (10) tick();
        start = 1'b1; tick(); start = 1'b0;
        n_tests++;
        if (state !== 2'd1 || countdown !== 2'd3 || p2_hp !== 4'd5 || winner !== 2'd0) begin
            n_fail++; $display("FAIL early_start: state=%0d cd=%0d hp=%0d winner=%0d expected 1/3/5/0", state, countdown, p2_hp, winner);
        end
    endtask

    task automatic test_reset_mid();
        repeat (3000) tick();
        p1_hit = 1'b1; p2_shoot = 1'b1; tick(); p1_hit = 1'b0;
        n_tests++;
        if (state !== 2'd2 || p1_hp !== 4'd4 || p2_fire !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_play: state=%0d hp=%0d p2_fire=%b expected 2/4/1", state, p1_hp, p2_fire);
        end
        reset = 1'b1; p2_shoot = 1'b0; tick(); reset = 1'b0;
        n_tests++;
        if (dut_vec() !== {2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd5, 4'd5, 2'd0}) begin
            n_fail++; $display("FAIL reset_mid_play: got %h expected %h", dut_vec(), {2'd0, 2'd0, 3'b000, 4'd5, 4'd5, 2'd0});
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 30000; k++) begin
            start        = ($urandom_range(0, 499) == 0);
            reset        = ($urandom_range(0, 7999) == 0);
            if ($urandom_range(0, 7) == 0) p1_shoot = ~p1_shoot;
            if ($urandom_range(0, 7) == 0) p2_shoot = ~p2_shoot;
            p1_proj_done = ($urandom_range(0, 29) == 0);
            p2_proj_done = ($urandom_range(0, 29) == 0);
            p1_hit       = ($urandom_range(0, 149) == 0);
            p2_hit       = ($urandom_range(0, 149) == 0);
            tick();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL random_cycle %0d: got %h expected %h", k, dut_vec(), model_vec());
            end
`ifdef POKEMON_AMMO_EN
            n_tests++;
            if (p1_ammo !== 4'(m_ammo1) || p2_ammo !== 4'(m_ammo2)) begin
                n_fail++; $display("FAIL random_ammo %0d: got %0d/%0d expected %0d/%0d", k, p1_ammo, p2_ammo, m_ammo1, m_ammo2);
            end
`endif
        end
        {start, reset, p1_shoot, p2_shoot, p1_proj_done, p2_proj_done, p1_hit, p2_hit} = '0;
        tick();
    endtask

`ifdef POKEMON_AMMO_EN
    task automatic test_ammo();
        reset = 1'b1; tick(); reset = 1'b0; tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (3000) tick();
        for (int i = 0; i < 9; i++) begin
            p1_proj_done = 1'b1; tick(); p1_proj_done = 1'b0;
            repeat (259) tick();
            p1_shoot = 1'b1; tick();
            n_tests++;
            if (p1_fire !== (i < 8)) begin n_fail++; $display("FAIL ammo_grant %0d: p1_fire=%b expected %b", i, p1_fire, i < 8); end
            p1_shoot = 1'b0; tick();
        end
        n_tests++;
        if (p1_ammo !== 4'd0) begin n_fail++; $display("FAIL ammo_empty: got %0d expected 0", p1_ammo); end
        repeat (1736) tick();
        n_tests++;
        if (p1_ammo !== 4'd0) begin n_fail++; $display("FAIL ammo_reload_early: got %0d expected 0", p1_ammo); end
        tick();
        n_tests++;
        if (p1_ammo !== 4'd8) begin n_fail++; $display("FAIL ammo_reloaded: got %0d expected 8", p1_ammo); end
    endtask
`endif

    initial begin
        test_reset();
        test_countdown();
        test_fire();
        test_back_to_back();
        test_draw();
        test_p2_ko();
        test_reset_mid();
        test_random();
`ifdef POKEMON_AMMO_EN
        test_ammo();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
